// File: rtl/logic_out_buffer.sv
// Elastic output stage after the logic unit: small FIFO on the forward token,
// registered upstream nack, combinational pass-through of backward t/v/c.
package logic_out_buffer_pkg;
    localparam int D_W = 16;
    localparam int I_W = 4;

    typedef struct packed {
        logic           v;
        logic           a;
        logic           c;
        logic           r;
        logic [I_W-1:0] i;
        logic [D_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
endpackage

module logic_out_buffer
    import logic_out_buffer_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int WIDTH_CNT = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Flush,
    input  FTk_t                 I_FTk,
    output BTk_t                 O_BTk,
    output FTk_t                 O_FTk,
    input  BTk_t                 I_BTk,
    output logic [WIDTH_CNT-1:0] O_Count,
    output logic                 O_Empty,
    output logic                 O_Full
);
    localparam int AW = $clog2(DEPTH);
    // Everything below the valid bit (MSB) is stored bit-exact.
    localparam int PW = $bits(FTk_t) - 1;

    logic [PW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [WIDTH_CNT-1:0] count_reg;
    logic                 push;
    logic                 pop;

    assign O_Empty = (count_reg == '0);
    assign O_Full  = (count_reg == WIDTH_CNT'(DEPTH));
    assign O_Count = count_reg;

    // Push sees only the registered full flag, so a pop in the same cycle
    // does not open the slot until the next cycle.
    assign push = I_FTk.v & ~O_Full & ~I_Flush;
    assign pop  = ~O_Empty & ~I_BTk.n & ~I_Flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (I_Flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    // Storage carries no reset; its contents are masked while empty.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr_reg] <= I_FTk[PW-1:0];
    end

    assign O_FTk = O_Empty ? FTk_t'('0) : FTk_t'({1'b1, mem[rd_ptr_reg]});

    always_comb begin
        O_BTk   = I_BTk;
        O_BTk.n = O_Full;
    end
endmodule

// File: tb/tb_logic_out_buffer.sv
// Bench for logic_out_buffer: directed plan steps followed by random traffic,
// all checked against a queue-based model of the FIFO.
module tb_logic_out_buffer;
    import logic_out_buffer_pkg::*;

    localparam int DEPTH = 2;
    localparam int WC    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    FTk_t          ftk_in = '0;
    BTk_t          btk_in = '0;
    FTk_t          ftk_out;
    BTk_t          btk_out;
    logic [WC-1:0] count;
    logic          empty;
    logic          full;

    FTk_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    logic_out_buffer #(.DEPTH(DEPTH)) dut (
        .clock  (clock),
        .reset  (reset),
        .I_Flush(flush),
        .I_FTk  (ftk_in),
        .O_BTk  (btk_out),
        .O_FTk  (ftk_out),
        .I_BTk  (btk_in),
        .O_Count(count),
        .O_Empty(empty),
        .O_Full (full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        FTk_t exp_ftk;
        int   sz;
        sz      = q.size();
        exp_ftk = (sz > 0) ? q[0] : FTk_t'('0);
        chk({tag, ":ftk"},   32'(ftk_out),   32'(exp_ftk));
        chk({tag, ":count"}, 32'(count),     32'(sz));
        chk({tag, ":empty"}, 32'(empty),     32'(sz == 0));
        chk({tag, ":full"},  32'(full),      32'(sz == DEPTH));
        chk({tag, ":nack"},  32'(btk_out.n), 32'(sz == DEPTH));
    endtask

    // One clock cycle: check state, drive inputs, clock, advance the model.
    task automatic step(input string tag, input logic v, input logic [15:0] d,
                        input logic c, input logic n, input logic fl);
        FTk_t tok;
        logic do_push, do_pop;
        check_outputs(tag);
        tok   = '0;
        tok.v = v;
        tok.a = 1'($urandom);
        tok.c = c;
        tok.r = 1'($urandom);
        tok.i = 4'($urandom);
        tok.d = d;
        ftk_in   = tok;
        btk_in.n = n;
        btk_in.t = 1'($urandom);
        btk_in.v = 1'($urandom);
        btk_in.c = 1'($urandom);
        flush    = fl;
        #1;
        chk({tag, ":bt"}, 32'(btk_out.t), 32'(btk_in.t));
        chk({tag, ":bv"}, 32'(btk_out.v), 32'(btk_in.v));
        chk({tag, ":bc"}, 32'(btk_out.c), 32'(btk_in.c));
        do_push = v && (q.size() < DEPTH) && !fl;
        do_pop  = (q.size() > 0) && !n && !fl;
        $display("%s: v=%0d d=%h n=%0d flush=%0d count=%0d push=%0d pop=%0d",
                 tag, v, d, n, fl, count, do_push, do_pop);
        @(posedge clock);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(tok);
        end
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_outputs("reset");
        reset = 1'b1;
        @(negedge clock);

        // Single token: one cycle latency, then drains.
        step("single_push", 1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        chk("single_d", 32'(ftk_out.d), 32'h5A5A);
        chk("single_c", 32'(ftk_out.c), 32'h1);
        step("single_pop", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step("single_idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Streaming at one token per cycle.
        for (int k = 1; k <= 8; k++)
            step("stream", 1'b1, 16'(k), 1'b0, 1'b0, 1'b0);
        chk("stream_count", 32'(count), 32'h1);
        step("stream_drain", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Fill under nack; C is refused, then released in order.
        step("nack_A", 1'b1, 16'h000A, 1'b0, 1'b1, 1'b0);
        step("nack_B", 1'b1, 16'h000B, 1'b0, 1'b1, 1'b0);
        chk("nack_full", 32'(full), 32'h1);
        step("nack_C_held", 1'b1, 16'h000C, 1'b0, 1'b1, 1'b0);
        step("nack_rel", 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        step("nack_retry", 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
        step("nack_d1", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step("nack_d2", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Full with simultaneous pop: push refused, count 2,1,2.
        step("fp_fill1", 1'b1, 16'h0011, 1'b0, 1'b1, 1'b0);
        step("fp_fill2", 1'b1, 16'h0022, 1'b0, 1'b1, 1'b0);
        step("fp_pop", 1'b1, 16'h0033, 1'b0, 1'b0, 1'b0);
        chk("fp_count1", 32'(count), 32'h1);
        step("fp_push", 1'b1, 16'h0033, 1'b0, 1'b1, 1'b0);
        chk("fp_count2", 32'(count), 32'h2);

        // Flush while full with a token presented.
        step("flush", 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'h0);
        step("flush_after", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream with two entries buffered.
        step("rst_fill1", 1'b1, 16'h0101, 1'b0, 1'b1, 1'b0);
        step("rst_fill2", 1'b1, 16'h0202, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_v", 32'(ftk_out.v), 32'h0);
        chk("rst_async_count", 32'(count), 32'h0);
        q.delete();
        @(negedge clock);
        check_outputs("rst_low");
        reset = 1'b1;
        for (int k = 0; k < 3; k++)
            step("rst_release", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 300; k++)
            step("random", ($urandom_range(3) != 0), 16'($urandom), 1'($urandom),
                 ($urandom_range(2) == 0), ($urandom_range(19) == 0));

        check_outputs("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/logic_out_buffer.md
Name: logic_out_buffer

Overview:
- Elastic output stage directly downstream of the logic unit (LogicUnit).
- Captures the forward token O_Result into a small FIFO and presents it to the next link.
- Converts the downstream nack (I_BTk.n) into a registered upstream nack, so no combinational path runs from I_BTk.n to O_BTk.n.
- Forwards the backward t/v/c tokens to the logic unit unchanged.

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2
WIDTH_CNT, $clog2(DEPTH)+1, occupancy counter width

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous active-low reset
I_Flush  in  1  synchronous flush; empties FIFO
I_FTk  in  FTk_t  forward token from logic unit (v,a,c,r,[i],d)
O_BTk  out  BTk_t  backward token to logic unit (n,t,v,c)
O_FTk  out  FTk_t  forward token to next link
I_BTk  in  BTk_t  backward token from next link
O_Count  out  WIDTH_CNT  current occupancy
O_Empty  out  1  occupancy == 0
O_Full  out  1  occupancy == DEPTH

Behaviour:
- Reset: the asynchronous active-low reset has these effects:
  - clears write pointer, read pointer and count;
  - O_FTk becomes all-zero (v=0);
  - O_BTk.n=0, O_Count=0, O_Empty=1, O_Full=0;
  - storage contents are don't-care.
  - Reset mid-transfer drops all buffered tokens; no token is emitted after release until a new push.
- Push: push = I_FTk.v & ~O_Full & ~I_Flush.
  - Stores the full FTk_t (a, c, r, [i], d) at the write pointer.
  - Write pointer increments modulo DEPTH (wrap from DEPTH-1 to 0).
- Pop: pop = ~O_Empty & ~I_BTk.n & ~I_Flush.
  - Read pointer increments modulo DEPTH.
- Output token:
  - O_FTk = entry at the read pointer, with O_FTk.v = ~O_Empty.
  - Driven from registers/storage only, with no combinational path from I_FTk.
  - Latency: a token pushed at edge k is visible on O_FTk after edge k, i.e. minimum 1 cycle.
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both or neither: unchanged.
- Upstream nack: O_BTk.n = O_Full, a function of the count register only.
  - When full, an arriving I_FTk.v=1 is not accepted. The logic unit must hold its token while O_BTk.n=1.
  - When full and popping in the same cycle, push is still refused (nack is registered); the slot frees for the next cycle.
- Throughput: with DEPTH=2 and I_BTk.n held 0, one token per cycle is sustained indefinitely (count steady at 1).
- Backward pass-through: O_BTk.t = I_BTk.t, O_BTk.v = I_BTk.v, O_BTk.c = I_BTk.c, all combinational.
  - The logic unit's own condition-to-backward muxing occurs upstream of this point.
- Flush:
  - Synchronous, highest priority; overrides push and pop in the same cycle.
  - Next cycle: count=0, pointers=0, O_FTk.v=0, O_BTk.n=0.
  - A token presented in the flush cycle is discarded.
- Ordering: strict FIFO. Fields a, c, r, d are carried bit-exact and never modified.
- Empty with I_BTk.n=1: no effect.
- Full with I_FTk.v=0: no effect.

Test Plan:
- Reset release, then push d=0x5A5A, c=1 with I_BTk.n=0 → O_FTk.v=1, d=0x5A5A, c=1 one cycle later; count 1→0 the following cycle; O_BTk.n stays 0.
- Stream 8 tokens d=1..8 on consecutive cycles with I_BTk.n=0 → O_FTk emits 1..8 on consecutive cycles; count never exceeds 1; no nack.
- Hold I_BTk.n=1 and push 3 tokens d=A,B,C:
  - After 2 pushes O_Full=1 and O_BTk.n=1; C is held upstream.
  - Release nack → output A, B, C in order; wrap-around occurs on the third write.
- Full FIFO, drop I_BTk.n and present I_FTk.v in the same cycle → pop occurs, push is refused that cycle; the token is accepted on the next cycle; count sequence 2,1,2.
- Full FIFO, assert I_Flush for 1 cycle with I_FTk.v=1 → next cycle count=0, O_FTk.v=0, O_BTk.n=0; the flushed-cycle token never appears on O_FTk.
- Toggle I_BTk.t/v/c each cycle, and separately drive reset low mid-stream with 2 entries buffered:
  - O_BTk.t/v/c mirror the inputs in the same cycle.
  - Reset immediately forces O_FTk.v=0, O_Count=0; no stale token appears after reset release.
